// File: rtl/pipe_sub_64.sv
// 64-bit subtractor, four 16-bit stages, valid/ready handshake.
// The borrow chain is cut at every slice boundary by a pipeline register.
module pipe_sub_64 #(
  parameter int SLICE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] D,
  output logic        Bout,
  output logic        Ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int DATA_W = 64;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Lookahead inside each nibble, group carries chained across the slice.
  function automatic logic [SLICE:0] add_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic ci);
    logic [SLICE:0] r;
    logic           c;
    logic [4:0]     grp;
    r = '0;
    c = ci;
    for (int i = 0; i < SLICE / 4; i++) begin
      grp        = cla4(a[4*i +: 4], b[4*i +: 4], c);
      r[4*i +: 4] = grp[3:0];
      c          = grp[4];
    end
    r[SLICE] = c;
    return r;
  endfunction

  logic                     en;
  logic [SLICE:0]           s0, s1, s2, s3;

  logic                     vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic                     vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
  logic [SLICE-1:0]         d_p0_q, d_p0_d;
  logic [2*SLICE-1:0]       d_p1_q, d_p1_d;
  logic [3*SLICE-1:0]       d_p2_q, d_p2_d;
  logic [DATA_W-1:0]        d_p3_q, d_p3_d;
  logic                     c_p0_q, c_p0_d, c_p1_q, c_p1_d, c_p2_q, c_p2_d;
  logic [DATA_W-1:SLICE]    a_p0_q, a_p0_d, bn_p0_q, bn_p0_d;
  logic [DATA_W-1:2*SLICE]  a_p1_q, a_p1_d, bn_p1_q, bn_p1_d;
  logic [DATA_W-1:3*SLICE]  a_p2_q, a_p2_d, bn_p2_q, bn_p2_d;
  logic                     bout_q, bout_d, ovf_q, ovf_d;

  always_comb begin
    en = ~vld_p3_q | out_ready;
    s0 = add_slice(A[SLICE-1:0], ~B[SLICE-1:0], ~Bin);
    s1 = add_slice(a_p0_q[2*SLICE-1:SLICE], bn_p0_q[2*SLICE-1:SLICE], c_p0_q);
    s2 = add_slice(a_p1_q[3*SLICE-1:2*SLICE], bn_p1_q[3*SLICE-1:2*SLICE], c_p1_q);
    s3 = add_slice(a_p2_q[DATA_W-1:3*SLICE], bn_p2_q[DATA_W-1:3*SLICE], c_p2_q);

    vld_p0_d = vld_p0_q;  vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;  vld_p3_d = vld_p3_q;
    d_p0_d   = d_p0_q;    d_p1_d   = d_p1_q;
    d_p2_d   = d_p2_q;    d_p3_d   = d_p3_q;
    c_p0_d   = c_p0_q;    c_p1_d   = c_p1_q;    c_p2_d = c_p2_q;
    a_p0_d   = a_p0_q;    bn_p0_d  = bn_p0_q;
    a_p1_d   = a_p1_q;    bn_p1_d  = bn_p1_q;
    a_p2_d   = a_p2_q;    bn_p2_d  = bn_p2_q;
    bout_d   = bout_q;    ovf_d    = ovf_q;

    if (en) begin
      // stage 0: bits [15:0] from the ports
      vld_p0_d = in_valid;
      d_p0_d   = s0[SLICE-1:0];
      c_p0_d   = s0[SLICE];
      a_p0_d   = A[DATA_W-1:SLICE];
      bn_p0_d  = ~B[DATA_W-1:SLICE];
      // stage 1: bits [31:16]
      vld_p1_d = vld_p0_q;
      d_p1_d   = {s1[SLICE-1:0], d_p0_q};
      c_p1_d   = s1[SLICE];
      a_p1_d   = a_p0_q[DATA_W-1:2*SLICE];
      bn_p1_d  = bn_p0_q[DATA_W-1:2*SLICE];
      // stage 2: bits [47:32]
      vld_p2_d = vld_p1_q;
      d_p2_d   = {s2[SLICE-1:0], d_p1_q};
      c_p2_d   = s2[SLICE];
      a_p2_d   = a_p1_q[DATA_W-1:3*SLICE];
      bn_p2_d  = bn_p1_q[DATA_W-1:3*SLICE];
      // stage 3: bits [63:48] and flags; inverted B sign means A/B signs differ when equal
      vld_p3_d = vld_p2_q;
      d_p3_d   = {s3[SLICE-1:0], d_p2_q};
      bout_d   = ~s3[SLICE];
      ovf_d    = (a_p2_q[DATA_W-1] == bn_p2_q[DATA_W-1]) & (s3[SLICE-1] != a_p2_q[DATA_W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      d_p3_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      d_p3_q   <= d_p3_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    d_p0_q  <= d_p0_d;
    d_p1_q  <= d_p1_d;
    d_p2_q  <= d_p2_d;
    c_p0_q  <= c_p0_d;
    c_p1_q  <= c_p1_d;
    c_p2_q  <= c_p2_d;
    a_p0_q  <= a_p0_d;
    bn_p0_q <= bn_p0_d;
    a_p1_q  <= a_p1_d;
    bn_p1_q <= bn_p1_d;
    a_p2_q  <= a_p2_d;
    bn_p2_q <= bn_p2_d;
  end

  assign in_ready  = en;
  assign out_valid = vld_p3_q;
  assign D         = d_p3_q;
  assign Bout      = bout_q;
  assign Ovf       = ovf_q;

endmodule
